// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall controller for the 5-stage RISC_TOY pipeline.
// Combinational stage controls; registered data-wait FSM and saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int unsigned AW      = 5,
    parameter int unsigned CNTW    = 16,
    parameter int unsigned MAXWAIT = 255,
    parameter bit          R0_ZERO = 1'b0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [AW-1:0]   RA0_D,
    input  logic [AW-1:0]   RA1_D,
    input  logic            USE0_D,
    input  logic            USE1_D,
    input  logic [AW-1:0]   RA0_E,
    input  logic [AW-1:0]   RA1_E,
    input  logic            USE0_E,
    input  logic            USE1_E,
    input  logic [AW-1:0]   WA_E,
    input  logic            WEN_E,
    input  logic            LOAD_E,
    input  logic [AW-1:0]   WA_M,
    input  logic            WEN_M,
    input  logic [AW-1:0]   WA_W,
    input  logic            WEN_W,
    input  logic            TAKEN_E,
    input  logic            IRDY,
    input  logic            DREQ_M,
    input  logic            DRDY,
    output logic            PCWrite,
    output logic            FDWrite,
    output logic            DEWrite,
    output logic            EMWrite,
    output logic            MWWrite,
    output logic            FDFlush,
    output logic            DEFlush,
    output logic [1:0]      FW1,
    output logic [1:0]      FW2,
    output logic            MEM_ERR,
    output logic [CNTW-1:0] STALL_CNT,
    output logic [CNTW-1:0] FLUSH_CNT,
    output logic [1:0]      DBG_STATE
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWAIT = 2'd1,
        ERR   = 2'd2
    } dstate_e;

    localparam logic [15:0]     MAXW = 16'(MAXWAIT);
    localparam logic [CNTW-1:0] CMAX = '1;

    dstate_e         state_q, state_d;
    logic [15:0]     wcnt_q, wcnt_d;
    logic [CNTW-1:0] stall_q, stall_d;
    logic [CNTW-1:0] flush_q, flush_d;

    logic freeze;
    logic lu;
    logic redirect;
    logic stall_inc;

    // Address 0 can be made a hard-wired zero register that never aliases a producer.
    function automatic logic match(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a == b) && !(R0_ZERO && (a == '0));
    endfunction

    function automatic logic [1:0] fw_sel(input logic use_e, input logic [AW-1:0] ra);
        if (use_e && WEN_M && match(ra, WA_M)) begin
            return 2'b01;
        end else if (use_e && WEN_W && match(ra, WA_W)) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    assign lu = LOAD_E && WEN_E &&
                ((USE0_D && match(RA0_D, WA_E)) || (USE1_D && match(RA1_D, WA_E)));

    // A DRDY in the same cycle as the request releases the freeze without a state visit.
    assign freeze    = (state_q == ERR) || (DREQ_M && !DRDY);
    assign redirect  = !freeze && TAKEN_E;
    assign stall_inc = freeze || lu || (!IRDY && !TAKEN_E);

    always_comb begin
        PCWrite = 1'b1;
        FDWrite = 1'b1;
        DEWrite = 1'b1;
        EMWrite = 1'b1;
        MWWrite = 1'b1;
        FDFlush = 1'b0;
        DEFlush = 1'b0;
        FW1     = fw_sel(USE0_E, RA0_E);
        FW2     = fw_sel(USE1_E, RA1_E);
        if (RST) begin
            PCWrite = 1'b0;
            FDWrite = 1'b0;
            DEWrite = 1'b0;
            EMWrite = 1'b0;
            MWWrite = 1'b0;
            FDFlush = 1'b1;
            DEFlush = 1'b1;
            FW1     = 2'b00;
            FW2     = 2'b00;
        end else if (freeze) begin
            PCWrite = 1'b0;
            FDWrite = 1'b0;
            DEWrite = 1'b0;
            EMWrite = 1'b0;
            MWWrite = 1'b0;
        end else if (TAKEN_E) begin
            FDFlush = 1'b1;
            DEFlush = 1'b1;
        end else if (lu) begin
            PCWrite = 1'b0;
            FDWrite = 1'b0;
            DEFlush = 1'b1;
        end else if (!IRDY) begin
            PCWrite = 1'b0;
            FDFlush = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (DREQ_M && !DRDY) begin
                    state_d = DWAIT;
                    wcnt_d  = 16'd1;
                end
            end
            DWAIT: begin
                if (DRDY) begin
                    state_d = IDLE;
                    wcnt_d  = 16'd0;
                end else if (wcnt_q == MAXW) begin
                    state_d = ERR;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
            end
            ERR:     state_d = ERR;
            default: begin
                state_d = IDLE;
                wcnt_d  = 16'd0;
            end
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_inc && (stall_q != CMAX)) begin
            stall_d = stall_q + CNTW'(1);
        end
        if (redirect && (flush_q != CMAX)) begin
            flush_d = flush_q + CNTW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            wcnt_q  <= 16'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign MEM_ERR   = (state_q == ERR);
    assign STALL_CNT = stall_q;
    assign FLUSH_CNT = flush_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: dut_a uses CNTW=4, MAXWAIT=4, R0_ZERO=1;
// dut_b uses default parameters and only shares the forwarding checks.
module tb_pipe_hazard_ctrl;

  localparam int AW = 5;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DWAIT = 2'd1;
  localparam logic [1:0] ST_ERR   = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] ra0_d, ra1_d, ra0_e, ra1_e, wa_e, wa_m, wa_w;
  logic use0_d, use1_d, use0_e, use1_e, wen_e, load_e, wen_m, wen_w;
  logic taken_e, irdy, dreq_m, drdy;

  logic a_pcw, a_fdw, a_dew, a_emw, a_mww, a_fdf, a_def, a_err;
  logic [1:0] a_fw1, a_fw2, a_st;
  logic [3:0] a_stall, a_flush;

  logic b_pcw, b_fdw, b_dew, b_emw, b_mww, b_fdf, b_def, b_err;
  logic [1:0] b_fw1, b_fw2, b_st;
  logic [15:0] b_stall, b_flush;

  int n_checks = 0;
  int n_errors = 0;

  pipe_hazard_ctrl #(.AW(AW), .CNTW(4), .MAXWAIT(4), .R0_ZERO(1'b1)) dut_a (
    .CLK(clk), .RST(rst),
    .RA0_D(ra0_d), .RA1_D(ra1_d), .USE0_D(use0_d), .USE1_D(use1_d),
    .RA0_E(ra0_e), .RA1_E(ra1_e), .USE0_E(use0_e), .USE1_E(use1_e),
    .WA_E(wa_e), .WEN_E(wen_e), .LOAD_E(load_e),
    .WA_M(wa_m), .WEN_M(wen_m), .WA_W(wa_w), .WEN_W(wen_w),
    .TAKEN_E(taken_e), .IRDY(irdy), .DREQ_M(dreq_m), .DRDY(drdy),
    .PCWrite(a_pcw), .FDWrite(a_fdw), .DEWrite(a_dew), .EMWrite(a_emw), .MWWrite(a_mww),
    .FDFlush(a_fdf), .DEFlush(a_def), .FW1(a_fw1), .FW2(a_fw2),
    .MEM_ERR(a_err), .STALL_CNT(a_stall), .FLUSH_CNT(a_flush), .DBG_STATE(a_st)
  );

  pipe_hazard_ctrl dut_b (
    .CLK(clk), .RST(rst),
    .RA0_D(ra0_d), .RA1_D(ra1_d), .USE0_D(use0_d), .USE1_D(use1_d),
    .RA0_E(ra0_e), .RA1_E(ra1_e), .USE0_E(use0_e), .USE1_E(use1_e),
    .WA_E(wa_e), .WEN_E(wen_e), .LOAD_E(load_e),
    .WA_M(wa_m), .WEN_M(wen_m), .WA_W(wa_w), .WEN_W(wen_w),
    .TAKEN_E(taken_e), .IRDY(irdy), .DREQ_M(dreq_m), .DRDY(drdy),
    .PCWrite(b_pcw), .FDWrite(b_fdw), .DEWrite(b_dew), .EMWrite(b_emw), .MWWrite(b_mww),
    .FDFlush(b_fdf), .DEFlush(b_def), .FW1(b_fw1), .FW2(b_fw2),
    .MEM_ERR(b_err), .STALL_CNT(b_stall), .FLUSH_CNT(b_flush), .DBG_STATE(b_st)
  );

  // driver tasks
  task automatic clear_inputs();
    ra0_d = '0; ra1_d = '0; ra0_e = '0; ra1_e = '0;
    wa_e = '0; wa_m = '0; wa_w = '0;
    use0_d = 0; use1_d = 0; use0_e = 0; use1_e = 0;
    wen_e = 0; load_e = 0; wen_m = 0; wen_w = 0;
    taken_e = 0; irdy = 1; dreq_m = 0; drdy = 0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {PCWrite,FDWrite,DEWrite,EMWrite,MWWrite,FDFlush,DEFlush}
  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    chk(tag, {25'd0, a_pcw, a_fdw, a_dew, a_emw, a_mww, a_fdf, a_def}, {25'd0, exp});
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    settle();
    chk_ctl("reset_ctl", 7'b00000_11);
    chk("reset_fw1", a_fw1, 2'b00);
    chk("reset_stall", a_stall, 4'd0);
    chk("reset_flush", a_flush, 4'd0);
    chk("reset_err", a_err, 1'b0);
    chk("reset_state", a_st, ST_IDLE);
    tick();
    rst = 1'b0;
    settle();
    chk_ctl("idle_ctl", 7'b11111_00);

    // forwarding: MEM over WB, then WB, then the zero register
    ra0_e = 5'd3; use0_e = 1; wen_m = 1; wa_m = 5'd3; wen_w = 1; wa_w = 5'd3;
    settle();
    chk("fw1_mem", a_fw1, 2'b01);
    chk("fw1_mem_b", b_fw1, 2'b01);
    chk("fw2_unused", a_fw2, 2'b00);
    wen_m = 0;
    settle();
    chk("fw1_wb", a_fw1, 2'b10);
    ra1_e = 5'd3; use1_e = 1;
    settle();
    chk("fw2_wb", a_fw2, 2'b10);
    wa_w = 5'd4;
    settle();
    chk("fw1_none", a_fw1, 2'b00);
    ra0_e = '0; ra1_e = '0; wa_m = '0; wa_w = '0; wen_m = 1; wen_w = 1;
    settle();
    chk("fw1_r0_zero", a_fw1, 2'b00);
    chk("fw1_r0_normal_b", b_fw1, 2'b01);
    tick();
    chk("fw_no_stall", a_stall, 4'd0);
    clear_inputs();

    // load-use stall lasts exactly one cycle
    load_e = 1; wen_e = 1; wa_e = 5'd7; ra1_d = 5'd7; use1_d = 1;
    settle();
    chk_ctl("lu_ctl", 7'b00111_01);
    tick();
    chk("lu_stall_cnt", a_stall, 4'd1);
    load_e = 0; wen_e = 0;
    settle();
    chk_ctl("lu_released", 7'b11111_00);
    tick();
    chk("lu_stall_hold", a_stall, 4'd1);

    // redirect overrides load-use
    load_e = 1; wen_e = 1; taken_e = 1;
    settle();
    chk_ctl("lu_taken_ctl", 7'b11111_11);
    tick();
    chk("lu_taken_flush", a_flush, 4'd1);
    clear_inputs();

    rst = 1'b1;
    settle();
    chk("rst2_stall", a_stall, 4'd0);
    chk("rst2_flush", a_flush, 4'd0);
    tick();
    rst = 1'b0;

    // data wait: three frozen cycles, released by DRDY on the fourth
    dreq_m = 1; drdy = 0;
    settle();
    chk_ctl("dw_c1_ctl", 7'b00000_00);
    chk("dw_c1_state", a_st, ST_IDLE);
    tick();
    chk_ctl("dw_c2_ctl", 7'b00000_00);
    chk("dw_c2_state", a_st, ST_DWAIT);
    chk("dw_c2_stall", a_stall, 4'd1);
    tick();
    chk_ctl("dw_c3_ctl", 7'b00000_00);
    tick();
    drdy = 1;
    settle();
    chk_ctl("dw_release_ctl", 7'b11111_00);
    tick();
    dreq_m = 0; drdy = 0;
    settle();
    chk("dw_end_state", a_st, ST_IDLE);
    chk("dw_end_stall", a_stall, 4'd3);

    // redirect deferred by freeze
    dreq_m = 1; drdy = 0; taken_e = 1;
    settle();
    chk_ctl("fr_tk_ctl", 7'b00000_00);
    tick();
    chk("fr_tk_flush_hold", a_flush, 4'd0);
    drdy = 1;
    settle();
    chk_ctl("fr_tk_release", 7'b11111_11);
    tick();
    chk("fr_tk_flush", a_flush, 4'd1);
    chk("fr_tk_stall", a_stall, 4'd4);
    clear_inputs();

    // fetch wait
    irdy = 0;
    settle();
    chk_ctl("if_c1_ctl", 7'b01111_10);
    tick();
    settle();
    chk_ctl("if_c2_ctl", 7'b01111_10);
    tick();
    chk("if_stall", a_stall, 4'd6);
    taken_e = 1;
    settle();
    chk_ctl("if_taken_ctl", 7'b11111_11);
    tick();
    chk("if_taken_stall", a_stall, 4'd6);
    chk("if_taken_flush", a_flush, 4'd2);
    clear_inputs();

    // timeout: ERR after four DWAIT cycles, sticky, saturating stall counter
    dreq_m = 1; drdy = 0;
    repeat (4) tick();
    chk("to_dwait", a_st, ST_DWAIT);
    chk("to_stall10", a_stall, 4'd10);
    tick();
    chk("to_err_state", a_st, ST_ERR);
    chk("to_mem_err", a_err, 1'b1);
    chk("to_stall11", a_stall, 4'd11);
    drdy = 1;
    settle();
    chk_ctl("to_err_ctl", 7'b00000_00);
    tick();
    chk("to_err_sticky", a_err, 1'b1);
    dreq_m = 0; drdy = 0;
    repeat (5) tick();
    chk("to_stall_sat", a_stall, 4'd15);
    chk("to_still_err", a_st, ST_ERR);

    // asynchronous reset out of ERR
    rst = 1'b1;
    settle();
    chk("rst_err_state", a_st, ST_IDLE);
    chk("rst_err_memerr", a_err, 1'b0);
    chk("rst_err_stall", a_stall, 4'd0);
    chk("rst_err_flush", a_flush, 4'd0);
    chk_ctl("rst_err_ctl", 7'b00000_11);
    tick();
    rst = 1'b0;

    // asynchronous reset out of DWAIT
    dreq_m = 1; drdy = 0;
    tick();
    tick();
    chk("rdw_state", a_st, ST_DWAIT);
    chk("rdw_stall", a_stall, 4'd2);
    rst = 1'b1;
    settle();
    chk("rdw_rst_state", a_st, ST_IDLE);
    chk("rdw_rst_stall", a_stall, 4'd0);
    tick();
    rst = 1'b0;
    clear_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard, forwarding and stall controller for the 5-stage RISC_TOY pipeline (IF/ID/EX/MEM/WB).
- Adds behaviour the current hazard unit lacks:
  - wait-state handshakes for instruction and data memory (IRDY/DRDY);
  - global pipeline freeze, with a memory-timeout error state;
  - branch/jump redirect flush;
  - saturating stall and flush performance counters.
- Drives write enables and flushes for PC, FD, DE, EM and MW, and the EX-stage forwarding selects.

Parameters:
- AW, 5, register address width.
- CNTW, 16, width of each performance counter.
- MAXWAIT, 255, consecutive data-wait cycles that trigger timeout (range 1..2^16-1).
- R0_ZERO, 0: if 1, register address 0 never matches for forwarding or hazard detection.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- RA0_D, RA1_D  in  AW  ID-stage source addresses.
- USE0_D, USE1_D  in  1  ID source actually read.
- RA0_E, RA1_E  in  AW  EX-stage source addresses.
- USE0_E, USE1_E  in  1  EX source actually read.
- WA_E  in  AW  EX destination.
- WEN_E  in  1  EX writes the register file.
- LOAD_E  in  1  EX instruction is a load.
- WA_M  in  AW  MEM destination.
- WEN_M  in  1  MEM writes the register file.
- WA_W  in  AW  WB destination.
- WEN_W  in  1  WB writes the register file.
- TAKEN_E  in  1  branch taken or jump in EX; redirect required.
- IRDY  in  1  instruction memory returned valid INSTR this cycle.
- DREQ_M  in  1  MEM stage has a data access.
- DRDY  in  1  data memory completes the access this cycle.
- PCWrite, FDWrite, DEWrite, EMWrite, MWWrite  out  1  stage-register load enables.
- FDFlush, DEFlush  out  1  load NOP/bubble into FD / DE at the next edge.
- FW1, FW2  out  2  forwarding selects: 00 = register file, 01 = ALUOUT_M, 10 = WBData.
- MEM_ERR  out  1  sticky data-memory timeout.
- STALL_CNT  out  CNTW  stall-cycle counter.
- FLUSH_CNT  out  CNTW  redirect counter.

Behaviour:
- Match rule: match(a,b) = (a==b) && !(R0_ZERO && a==0).
- Forwarding (combinational):
  - FWx=01 if USEx_E && WEN_M && match(RAx_E, WA_M).
  - Otherwise FWx=10 if USEx_E && WEN_W && match(RAx_E, WA_W).
  - Otherwise FWx=00.
  - MEM has priority over WB.
- Load-use hazard (LU) = LOAD_E && WEN_E && ((USE0_D && match(RA0_D,WA_E)) || (USE1_D && match(RA1_D,WA_E))).
- Data-wait FSM, states IDLE, DWAIT, ERR (registered); wait counter WCNT 16-bit:
  - IDLE: if DREQ_M && !DRDY, go to DWAIT with WCNT=1.
  - DWAIT: DRDY goes to IDLE. Otherwise, if WCNT==MAXWAIT go to ERR; else WCNT+1.
  - ERR: held until RST; MEM_ERR=1.
- FREEZE = (state==ERR) || (DREQ_M && !DRDY), evaluated combinationally, so a DRDY arriving in the same cycle releases immediately.
- Control outputs, first matching row wins (enables not listed = 1; flushes not listed = 0):
  1. RST high: all enables 0, FDFlush=DEFlush=1, FW=00.
  2. FREEZE: all five enables 0, both flushes 0. Redirect and LU are deferred; they re-evaluate when the freeze lifts, because the EX and ID contents are held.
  3. TAKEN_E: PCWrite=1, FDFlush=1, DEFlush=1. This overrides LU and !IRDY.
  4. LU: PCWrite=0, FDWrite=0, DEFlush=1. This also covers !IRDY.
  5. !IRDY: PCWrite=0, FDFlush=1, downstream stages advance.
  6. Otherwise: all enables 1, no flush.
- A flush is never asserted together with the same stage's write enable at 0, except during reset.
- Counters (registered, saturate at all-ones, no wrap):
  - STALL_CNT +1 each cycle with FREEZE, or LU, or !IRDY with no TAKEN_E.
  - FLUSH_CNT +1 each cycle row 3 applies.
- Reset values: state IDLE, WCNT=0, MEM_ERR=0, STALL_CNT=0, FLUSH_CNT=0.
- Reset asserted mid-wait or in ERR returns to IDLE asynchronously.
- Latency: all control outputs combinational from inputs and current state. The state change is visible one cycle later.

Test Plan:
- Forwarding: EX RA0_E=3, USE0_E=1; WEN_M=1, WA_M=3; WEN_W=1, WA_W=3 -> FW1=01. Set WEN_M=0 -> FW1=10. With R0_ZERO=1 and all addresses 0 -> FW1=00.
- Load-use: LOAD_E=1, WEN_E=1, WA_E=7, RA1_D=7, USE1_D=1 -> PCWrite=0, FDWrite=0, DEFlush=1 for exactly one cycle; STALL_CNT +1. Same case with TAKEN_E=1 -> FDFlush=DEFlush=1, PCWrite=1, FLUSH_CNT +1.
- Data wait: DREQ_M=1, DRDY low for 3 cycles then high -> all enables 0 for 3 cycles, released on the 4th; state IDLE; STALL_CNT=3. With MAXWAIT=4 and DRDY held low -> ERR after 4 DWAIT cycles, MEM_ERR=1 stays set after DRDY rises, enables stay 0.
- Fetch wait: IRDY=0 for 2 cycles -> PCWrite=0, FDFlush=1, DEWrite=EMWrite=MWWrite=1. IRDY=0 with TAKEN_E=1 -> PCWrite=1, both flushes asserted.
- Freeze plus redirect: TAKEN_E=1 during FREEZE -> no flush and FLUSH_CNT unchanged; on release, flush fires and FLUSH_CNT +1.
- Reset and saturation: with CNTW=4, drive 20 stall cycles -> STALL_CNT=15. Assert RST in DWAIT -> counters 0, MEM_ERR 0, FSM IDLE immediately.
